// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART with per-direction baud tick generation.
//
// Both directions latch baud_div, parity_mode and stop2 when a frame starts, so
// reprogramming mid-frame only affects the next frame. Each direction runs its own
// tick counter from its latched divisor; a tick occurs every baud_div+1 clk.
//
// Build option: define UART_RX_FIFO_EN to place an RX_FIFO_DEPTH-entry FIFO
// (data + flags) in front of the rx outputs. Otherwise a single holding register is used.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   baud_div                   tick every baud_div+1 clk cycles
//   parity_mode                00/11 none, 01 even, 10 odd
//   stop2                      two TX stop bits when 1
//   rx_uart / tx_uart          serial lines (tx idles high)
//   tx_data_valid/ready, tx_data
//                              TX byte handshake, LSB first on the line
//   rx_data_valid/ready, rx_data, rx_parity_error, rx_frame_error
//                              RX byte handshake; flags qualify rx_data
//   rx_overrun                 one-cycle pulse when a completed frame is dropped
module uart_transceiver #(
    parameter int DATA_WIDTH    = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int DIV_WIDTH     = 16,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    input  logic                  rx_uart,
    output logic                  tx_uart,
    input  logic                  tx_data_valid,
    output logic                  tx_data_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  rx_data_valid,
    input  logic                  rx_data_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_parity_error,
    output logic                  rx_frame_error,
    output logic                  rx_overrun
);

    localparam int              OS_W     = $clog2(OVERSAMPLE) + 1;
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]      BIT_LAST = 4'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // ---------------------------------------------------------------- transmitter
    logic [2:0]            tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0]  tx_div_q, tx_div_d;
    logic [DIV_WIDTH-1:0]  tx_tcnt_q, tx_tcnt_d;
    logic [OS_W-1:0]       tx_samp_q, tx_samp_d;
    logic [3:0]            tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_en_q, tx_par_en_d;
    logic                  tx_par_bit_q, tx_par_bit_d;
    logic                  tx_stop2_q, tx_stop2_d;
    logic                  tx_line_q, tx_line_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  tx_tick, tx_bit_end;

    assign tx_tick       = (tx_tcnt_q == tx_div_q);
    assign tx_uart       = tx_line_q;
    assign tx_data_ready = tx_ready_q;

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_div_d     = tx_div_q;
        tx_tcnt_d    = tx_tcnt_q;
        tx_samp_d    = tx_samp_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_par_en_d  = tx_par_en_q;
        tx_par_bit_d = tx_par_bit_q;
        tx_stop2_d   = tx_stop2_q;
        tx_bit_end   = 1'b0;

        if (tx_state_q == ST_IDLE) begin
            tx_tcnt_d = '0;
            tx_samp_d = '0;
            tx_bit_d  = '0;
            if (tx_data_valid && tx_ready_q) begin
                tx_state_d   = ST_START;
                tx_div_d     = baud_div;
                tx_shift_d   = tx_data;
                tx_par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                tx_par_bit_d = (^tx_data) ^ (parity_mode == 2'b10);
                tx_stop2_d   = stop2;
            end
        end else begin
            if (tx_tick) begin
                tx_tcnt_d = '0;
                if (tx_samp_q == OS_LAST) begin
                    tx_samp_d  = '0;
                    tx_bit_end = 1'b1;
                end else begin
                    tx_samp_d = tx_samp_q + 1'b1;
                end
            end else begin
                tx_tcnt_d = tx_tcnt_q + 1'b1;
            end

            if (tx_bit_end) begin
                case (tx_state_q)
                    ST_START: begin
                        tx_state_d = ST_DATA;
                        tx_bit_d   = '0;
                    end
                    ST_DATA: begin
                        tx_shift_d = tx_shift_q >> 1;
                        if (tx_bit_q == BIT_LAST) begin
                            tx_bit_d   = '0;
                            tx_state_d = tx_par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            tx_bit_d = tx_bit_q + 1'b1;
                        end
                    end
                    ST_PARITY: tx_state_d = ST_STOP;
                    ST_STOP: begin
                        // tx_bit_q counts stop bits already sent
                        if (tx_stop2_q && (tx_bit_q == 4'd0)) begin
                            tx_bit_d = 4'd1;
                        end else begin
                            tx_state_d = ST_IDLE;
                        end
                    end
                    default: tx_state_d = ST_IDLE;
                endcase
            end
        end

        // Line value is registered from the next state so the pin never glitches.
        case (tx_state_d)
            ST_START:  tx_line_d = 1'b0;
            ST_DATA:   tx_line_d = tx_shift_d[0];
            ST_PARITY: tx_line_d = tx_par_bit_d;
            default:   tx_line_d = 1'b1;
        endcase
        tx_ready_d = (tx_state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= ST_IDLE;
            tx_div_q     <= '0;
            tx_tcnt_q    <= '0;
            tx_samp_q    <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
            tx_stop2_q   <= 1'b0;
            tx_line_q    <= 1'b1;
            tx_ready_q   <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_div_q     <= tx_div_d;
            tx_tcnt_q    <= tx_tcnt_d;
            tx_samp_q    <= tx_samp_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_par_bit_q <= tx_par_bit_d;
            tx_stop2_q   <= tx_stop2_d;
            tx_line_q    <= tx_line_d;
            tx_ready_q   <= tx_ready_d;
        end
    end

    // ---------------------------------------------------------------- receiver
    logic                  rx_s1_q, rx_s2_q, rx_prev_q;
    logic                  rx_fall;
    logic [2:0]            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0]  rx_div_q, rx_div_d;
    logic [DIV_WIDTH-1:0]  rx_tcnt_q, rx_tcnt_d;
    logic [OS_W-1:0]       rx_samp_q, rx_samp_d;
    logic [3:0]            rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_par_en_q, rx_par_en_d;
    logic                  rx_par_odd_q, rx_par_odd_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_tick, rx_bit_end, rx_done;
    logic [OS_W-1:0]       rx_samp_last;

    assign rx_fall      = rx_prev_q & ~rx_s2_q;
    assign rx_tick      = (rx_tcnt_q == rx_div_q);
    // Start bit is sampled at its midpoint; later bits one full bit apart from there.
    assign rx_samp_last = (rx_state_q == ST_START) ? OS_HALF : OS_LAST;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_div_d     = rx_div_q;
        rx_tcnt_d    = rx_tcnt_q;
        rx_samp_d    = rx_samp_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_perr_d    = rx_perr_q;
        rx_bit_end   = 1'b0;
        rx_done      = 1'b0;

        if (rx_state_q == ST_IDLE) begin
            rx_tcnt_d = '0;
            rx_samp_d = '0;
            rx_bit_d  = '0;
            if (rx_fall) begin
                rx_state_d   = ST_START;
                rx_div_d     = baud_div;
                rx_par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                rx_par_odd_d = (parity_mode == 2'b10);
                rx_perr_d    = 1'b0;
            end
        end else begin
            if (rx_tick) begin
                rx_tcnt_d = '0;
                if (rx_samp_q == rx_samp_last) begin
                    rx_samp_d  = '0;
                    rx_bit_end = 1'b1;
                end else begin
                    rx_samp_d = rx_samp_q + 1'b1;
                end
            end else begin
                rx_tcnt_d = rx_tcnt_q + 1'b1;
            end

            if (rx_bit_end) begin
                case (rx_state_q)
                    // High at the start midpoint means the edge was a glitch.
                    ST_START: rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                    ST_DATA: begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
                        if (rx_bit_q == BIT_LAST) begin
                            rx_bit_d   = '0;
                            rx_state_d = rx_par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        rx_perr_d  = rx_s2_q ^ (^rx_shift_q) ^ rx_par_odd_q;
                        rx_state_d = ST_STOP;
                    end
                    ST_STOP: begin
                        rx_done    = 1'b1;
                        rx_state_d = ST_IDLE;
                    end
                    default: rx_state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_div_q     <= '0;
            rx_tcnt_q    <= '0;
            rx_samp_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_perr_q    <= 1'b0;
        end else begin
            rx_s1_q      <= rx_uart;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_div_q     <= rx_div_d;
            rx_tcnt_q    <= rx_tcnt_d;
            rx_samp_q    <= rx_samp_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            rx_perr_q    <= rx_perr_d;
        end
    end

    // ---------------------------------------------------------------- rx output stage
`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(RX_FIFO_DEPTH + 1);

    // Entry layout: {parity_error, frame_error, data}
    logic [DATA_WIDTH+1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [DATA_WIDTH+1:0] rx_word, head_word;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  fifo_full, fifo_push, fifo_pop, overrun_q;

    assign rx_word   = {rx_perr_q, ~rx_s2_q, rx_shift_q};
    assign fifo_full = (cnt_q == CNT_W'(RX_FIFO_DEPTH));
    assign fifo_pop  = (cnt_q != '0) && rx_data_ready;
    // A pop on the same cycle frees a slot for the completing frame.
    assign fifo_push = rx_done && (!fifo_full || fifo_pop);
    assign head_word = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= rx_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= rx_done && !fifo_push;
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (fifo_pop && !fifo_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Gate with valid so nothing from uninitialised storage reaches the pins.
    assign rx_data_valid   = (cnt_q != '0);
    assign rx_data         = rx_data_valid ? head_word[DATA_WIDTH-1:0] : '0;
    assign rx_frame_error  = rx_data_valid & head_word[DATA_WIDTH];
    assign rx_parity_error = rx_data_valid & head_word[DATA_WIDTH+1];
    assign rx_overrun      = overrun_q;
`else
    logic                  hold_valid_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_perr_q, hold_ferr_q, overrun_q;
    logic                  unused_fifo_depth;

    // Depth only matters when the FIFO is built.
    assign unused_fifo_depth = ^RX_FIFO_DEPTH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_perr_q  <= 1'b0;
            hold_ferr_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= rx_done && hold_valid_q && !rx_data_ready;
            if (rx_done && (!hold_valid_q || rx_data_ready)) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= rx_shift_q;
                hold_perr_q  <= rx_perr_q;
                hold_ferr_q  <= ~rx_s2_q;
            end else if (hold_valid_q && rx_data_ready) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data_valid   = hold_valid_q;
    assign rx_data         = hold_data_q;
    assign rx_parity_error = hold_valid_q & hold_perr_q;
    assign rx_frame_error  = hold_valid_q & hold_ferr_q;
    assign rx_overrun      = overrun_q;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver (default parameters, 8 data bits, x16).
// Received frames are checked through a scoreboard queue: expectations are pushed
// when a frame is driven and popped when the DUT hands a byte over.
module tb_uart_transceiver;

    logic        clk;
    logic        reset;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        rx_uart;
    logic        tx_uart;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic [7:0]  tx_data;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic [7:0]  rx_data;
    logic        rx_parity_error;
    logic        rx_frame_error;
    logic        rx_overrun;

    logic        rx_drv;
    logic        loopback;

    int          n_tests;
    int          n_fail;
    int          rx_pops;
    int          ovr_cnt;
    int          mark;
    logic [9:0]  exp_q[$];    // {parity_error, frame_error, data}
    logic [9:0]  mon_e;

    assign rx_uart = loopback ? tx_uart : rx_drv;

    uart_transceiver dut (
        .clk             (clk),
        .reset           (reset),
        .baud_div        (baud_div),
        .parity_mode     (parity_mode),
        .stop2           (stop2),
        .rx_uart         (rx_uart),
        .tx_uart         (tx_uart),
        .tx_data_valid   (tx_data_valid),
        .tx_data_ready   (tx_data_ready),
        .tx_data         (tx_data),
        .rx_data_valid   (rx_data_valid),
        .rx_data_ready   (rx_data_ready),
        .rx_data         (rx_data),
        .rx_parity_error (rx_parity_error),
        .rx_frame_error  (rx_frame_error),
        .rx_overrun      (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: a transfer is visible at the negedge before the clk that takes it.
    always @(negedge clk) begin
        if (rx_overrun) ovr_cnt++;
        if (rx_data_valid && rx_data_ready) begin
            rx_pops++;
            if (exp_q.size() == 0) begin
                check_val("rx_unexpected_byte", 0, 1);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("rx_data", {24'd0, rx_data}, {24'd0, mon_e[7:0]});
                check_val("rx_frame_error", {31'd0, rx_frame_error}, {31'd0, mon_e[8]});
                check_val("rx_parity_error", {31'd0, rx_parity_error}, {31'd0, mon_e[9]});
            end
        end
    end

    task automatic tx_handshake(input logic [7:0] data);
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        tx_data       = data;
        tx_data_valid = 1'b1;
        @(negedge clk);
        while (!tx_data_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check_val("tx_ready_timeout", {31'd0, tx_data_ready}, 1);
        @(posedge clk);
        #1;
        tx_data_valid = 1'b0;
    endtask

    // Sends one byte and checks the first and last clk of every bit, then ready timing.
    task automatic tx_send_check(input logic [7:0] data, input int div, input logic [1:0] pm,
                                 input logic two_stop);
        logic [11:0] bits;
        int nb;
        int bit_clk;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        nb = 9;
        if (pm == 2'b01 || pm == 2'b10) begin
            bits[nb] = (^data) ^ (pm == 2'b10);
            nb++;
        end
        nb = nb + (two_stop ? 2 : 1);
        bit_clk = 16 * (div + 1);
        tx_handshake(data);
        @(negedge clk);
        for (int c = 0; c < nb * bit_clk; c++) begin
            if ((c % bit_clk == 0) || (c % bit_clk == bit_clk - 1))
                check_val("tx_bit", {31'd0, tx_uart}, {31'd0, bits[c / bit_clk]});
            if (c == nb * bit_clk - 1) check_val("tx_ready_busy", {31'd0, tx_data_ready}, 0);
            @(negedge clk);
        end
        check_val("tx_idle_line", {31'd0, tx_uart}, 1);
        check_val("tx_ready_back", {31'd0, tx_data_ready}, 1);
    endtask

    // Bit-bangs one frame on rx at 16 clk per bit (baud_div = 0), then idles the line.
    task automatic rx_frame(input logic [7:0] data, input logic [1:0] pm, input logic bad_par,
                            input logic stop_bit);
        logic [10:0] bits;
        int nb;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        nb = 9;
        if (pm == 2'b01 || pm == 2'b10) begin
            bits[nb] = (^data) ^ (pm == 2'b10) ^ bad_par;
            nb++;
        end
        bits[nb] = stop_bit;
        nb++;
        for (int i = 0; i < nb; i++) begin
            @(posedge clk);
            #1;
            rx_drv = bits[i];
            repeat (15) @(posedge clk);
        end
        @(posedge clk);
        #1;
        rx_drv = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("rx_drain", exp_q.size(), 0);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rx_pops       = 0;
        ovr_cnt       = 0;
        reset         = 1'b0;
        baud_div      = 16'd0;
        parity_mode   = 2'b00;
        stop2         = 1'b0;
        rx_drv        = 1'b1;
        loopback      = 1'b0;
        tx_data_valid = 1'b0;
        tx_data       = 8'h00;
        rx_data_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_tx_line", {31'd0, tx_uart}, 1);
        check_val("rst_tx_ready", {31'd0, tx_data_ready}, 0);
        check_val("rst_rx_valid", {31'd0, rx_data_valid}, 0);
        check_val("rst_flags", {29'd0, rx_parity_error, rx_frame_error, rx_overrun}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("ready_before_first_edge", {31'd0, tx_data_ready}, 0);
        @(negedge clk);
        check_val("ready_after_release", {31'd0, tx_data_ready}, 1);

        // Basic TX waveform: 0xA5, no parity, one stop bit
        tx_send_check(8'hA5, 0, 2'b00, 1'b0);

        // Loopback with odd parity
        loopback    = 1'b1;
        parity_mode = 2'b10;
        exp_q.push_back({1'b0, 1'b0, 8'h03});
        tx_send_check(8'h03, 0, 2'b10, 1'b0);
        wait_drain(400);
        loopback    = 1'b0;
        parity_mode = 2'b00;

        // Frame error is still delivered
        exp_q.push_back({1'b0, 1'b1, 8'h55});
        rx_frame(8'h55, 2'b00, 1'b0, 1'b0);
        wait_drain(100);

        // Short low glitch on the idle line
        mark = rx_pops;
        @(posedge clk);
        #1;
        rx_drv = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_val("glitch_no_pop", rx_pops, mark);
        check_val("glitch_no_valid", {31'd0, rx_data_valid}, 0);

        // Parity checking, even then odd
        parity_mode = 2'b01;
        exp_q.push_back({1'b1, 1'b0, 8'h3C});
        rx_frame(8'h3C, 2'b01, 1'b1, 1'b1);
        exp_q.push_back({1'b0, 1'b0, 8'h7E});
        rx_frame(8'h7E, 2'b01, 1'b0, 1'b1);
        parity_mode = 2'b10;
        exp_q.push_back({1'b0, 1'b0, 8'h80});
        rx_frame(8'h80, 2'b10, 1'b0, 1'b1);
        exp_q.push_back({1'b1, 1'b0, 8'h81});
        rx_frame(8'h81, 2'b10, 1'b1, 1'b1);
        wait_drain(100);
        parity_mode = 2'b00;

        // Three frames while the consumer stalls
        rx_data_ready = 1'b0;
        mark = ovr_cnt;
        exp_q.push_back({1'b0, 1'b0, 8'h11});
`ifdef UART_RX_FIFO_EN
        exp_q.push_back({1'b0, 1'b0, 8'h22});
        exp_q.push_back({1'b0, 1'b0, 8'h33});
`endif
        rx_frame(8'h11, 2'b00, 1'b0, 1'b1);
        rx_frame(8'h22, 2'b00, 1'b0, 1'b1);
        rx_frame(8'h33, 2'b00, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("stall_valid", {31'd0, rx_data_valid}, 1);
        check_val("stall_head_data", {24'd0, rx_data}, 32'h11);
`ifdef UART_RX_FIFO_EN
        check_val("stall_overruns", ovr_cnt - mark, 0);
`else
        check_val("stall_overruns", ovr_cnt - mark, 2);
`endif
        rx_data_ready = 1'b1;
        wait_drain(50);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("stall_drained_valid", {31'd0, rx_data_valid}, 0);

        // Frame completes on the same clk the held byte is taken: no overrun
        rx_data_ready = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 8'h11});
        rx_frame(8'h11, 2'b00, 1'b0, 1'b1);
        mark = ovr_cnt;
        exp_q.push_back({1'b0, 1'b0, 8'h22});
        fork
            rx_frame(8'h22, 2'b00, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1;
                rx_data_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_data_ready = 1'b0;
            end
        join
        @(negedge clk);
        check_val("same_cycle_overrun", ovr_cnt - mark, 0);
        check_val("same_cycle_pending", exp_q.size(), 1);
        check_val("same_cycle_held", {24'd0, rx_data}, 32'h22);
        rx_data_ready = 1'b1;
        wait_drain(50);

        // Reset in the middle of data bit 3
        tx_handshake(8'hC6);
        repeat (72) @(posedge clk);
        @(negedge clk);
        check_val("mid_frame_bit3", {31'd0, tx_uart}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("rst_tx_immediate", {31'd0, tx_uart}, 1);
        check_val("rst_ready_low", {31'd0, tx_data_ready}, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("rerelease_ready_low", {31'd0, tx_data_ready}, 0);
        @(negedge clk);
        check_val("rerelease_ready_high", {31'd0, tx_data_ready}, 1);
        tx_send_check(8'h5A, 0, 2'b00, 1'b0);

        // Divisor and framing changed mid-frame only affect the next frame
        loopback    = 1'b1;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 8'hF0});
        fork
            tx_send_check(8'hF0, 4, 2'b00, 1'b0);
            begin
                repeat (100) @(posedge clk);
                #1;
                baud_div    = 16'd9;
                parity_mode = 2'b01;
                stop2       = 1'b1;
            end
        join
        exp_q.push_back({1'b0, 1'b0, 8'h3B});
        tx_send_check(8'h3B, 9, 2'b01, 1'b1);
        wait_drain(2000);
        loopback = 1'b0;

        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
